// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory lane controller: funct3 sizes and FSM states.
package dmem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, RDWAIT, ERR, RESP} state_e;
endpackage

// File: rtl/load_extract.sv
// Picks the addressed byte/halfword out of an SRAM word and sign/zero-extends it.
module load_extract
  import dmem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);
  logic [31:0] lane;
  assign lane = rdata_i >> {offset_i, 3'b000};

  always_comb begin
    data_o = rdata_i;
    case (funct3_i)
      F3_B:    data_o = {{24{lane[7]}}, lane[7:0]};
      F3_H:    data_o = {{16{lane[15]}}, lane[15:0]};
      F3_BU:   data_o = {24'h0, lane[7:0]};
      F3_HU:   data_o = {16'h0, lane[15:0]};
      default: data_o = rdata_i;
    endcase
  end
endmodule

// File: rtl/dmem_lane_ctrl.sv
// Load/store lane controller: steers stores onto byte strobes, extends loads,
// and turns illegal/misaligned requests into error responses without touching memory.
module dmem_lane_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int SIZE       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [SIZE-1:0]       req_wdata,
  output logic                  resp_valid,
  output logic [SIZE-1:0]       resp_rdata,
  output logic                  resp_err,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [SIZE-1:0]       mem_wdata,
  input  logic [SIZE-1:0]       mem_rdata
);
  state_e          state_q, state_d;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [SIZE-1:0] rdata_q, rdata_d, ext;
  logic            err_q, err_d;
  logic            hs, legal, misal, req_err;
  logic [3:0]      strb;
  logic [SIZE-1:0] wsteer;
  logic            unused_addr;

  assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];

  always_comb begin
    case (req_funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = !req_we;
      default:          legal = 1'b0;
    endcase
    misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
            ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    req_err = !legal || misal;
    case (req_funct3[1:0])
      2'b00: begin
        strb   = 4'b0001 << req_addr[1:0];
        wsteer = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        strb   = req_addr[1] ? 4'b1100 : 4'b0011;
        wsteer = {2{req_wdata[15:0]}};
      end
      default: begin
        strb   = 4'b1111;
        wsteer = req_wdata;
      end
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign hs         = req_valid && req_ready;
  assign mem_en     = hs && !req_err;
  assign mem_we     = (mem_en && req_we) ? strb : 4'b0000;
  assign mem_addr   = req_addr[ADDR_WIDTH+1:2];
  assign mem_wdata  = wsteer;
  // ERR is itself the error-response cycle, so errors answer at T+1 like stores.
  assign resp_valid = (state_q == ERR) || (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  load_extract u_extract (
    .rdata_i  (mem_rdata),
    .offset_i (off_q),
    .funct3_i (f3_q),
    .data_o   (ext)
  );

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (hs) begin
        if (req_err || req_we) begin
          rdata_d = '0;
          err_d   = req_err;
        end
        state_d = req_err ? ERR : (req_we ? RESP : RDWAIT);
      end
      RDWAIT: begin
        rdata_d = ext;
        err_d   = 1'b0;
        state_d = RESP;
      end
      ERR:     state_d = IDLE;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      f3_q    <= '0;
      off_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (hs) begin
        f3_q  <= req_funct3;
        off_q <= req_addr[1:0];
      end
    end
  end
endmodule

// File: tb/tb_dmem_lane_ctrl.sv
// Directed bench with a byte-maskable SRAM model and a response scoreboard.
module tb_dmem_lane_ctrl;
  import dmem_pkg::*;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr, req_wdata;
  logic          resp_valid, resp_err;
  logic [31:0]   resp_rdata;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'h0;
  logic [31:0]   sram [0:(1<<AW)-1];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic [31:0] rdata; logic err; int lat; } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  dmem_lane_ctrl #(.ADDR_WIDTH(AW), .SIZE(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == 4'b0000) mem_rdata <= sram[mem_addr];
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) sram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Waits for the response after a handshake edge and checks it against the scoreboard.
  task automatic collect(input string tag);
    exp_t e;
    int lat = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (resp_valid) begin lat = c; break; end
    end
    e = sb.pop_front();
    chk({tag, " latency"}, 32'(lat), 32'(e.lat));
    if (lat != 0) begin
      chk({tag, " rdata"}, resp_rdata, e.rdata);
      chk({tag, " err"}, 32'(resp_err), 32'(e.err));
    end
    @(negedge clk);
    chk({tag, " pulse"}, 32'(resp_valid), 32'd0);
    chk({tag, " held rdata"}, resp_rdata, e.rdata);
  endtask

  // Called at a falling edge; leaves the bench at a falling edge.
  task automatic req(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic x_en, input logic [3:0] x_we, input logic [31:0] x_wd,
                     input logic [31:0] x_rd, input logic x_err);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    #1;
    chk({tag, " ready"}, 32'(req_ready), 32'd1);
    chk({tag, " mem_en"}, 32'(mem_en), 32'(x_en));
    chk({tag, " mem_we"}, 32'(mem_we), 32'(x_we));
    if (x_en) chk({tag, " mem_addr"}, 32'(mem_addr), 32'(addr[AW+1:2]));
    if (x_en && we) chk({tag, " mem_wdata"}, mem_wdata, x_wd);
    sb.push_back('{x_rd, x_err, (x_err || we) ? 1 : 2});
    @(posedge clk); #1;
    req_valid = 1'b0;
    collect(tag);
  endtask

  initial begin
    exp_t e;
    for (int i = 0; i < (1<<AW); i++) sram[i] = 32'h0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    @(negedge clk); @(negedge clk);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_err", 32'(resp_err), 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst ready", 32'(req_ready), 32'd1);
    chk("rst mem_en", 32'(mem_en), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    req("SW",  1'b1, F3_W,  32'h100, 32'hDEADBEEF, 1'b1, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0);
    req("LW",  1'b0, F3_W,  32'h100, 32'h0, 1'b1, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b0);
    req("SB",  1'b1, F3_B,  32'h103, 32'h000000A5, 1'b1, 4'b1000, 32'hA5A5A5A5, 32'h0, 1'b0);
    req("LB",  1'b0, F3_B,  32'h103, 32'h0, 1'b1, 4'b0000, 32'h0, 32'hFFFFFFA5, 1'b0);
    req("LBU", 1'b0, F3_BU, 32'h103, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h000000A5, 1'b0);
    req("SH",  1'b1, F3_H,  32'h102, 32'h00008001, 1'b1, 4'b1100, 32'h80018001, 32'h0, 1'b0);
    req("LH",  1'b0, F3_H,  32'h102, 32'h0, 1'b1, 4'b0000, 32'h0, 32'hFFFF8001, 1'b0);
    req("LHU", 1'b0, F3_HU, 32'h102, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h00008001, 1'b0);
    req("LW low bytes kept", 1'b0, F3_W, 32'h100, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h8001BEEF, 1'b0);
    req("LW mis",  1'b0, F3_W,   32'h101, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
    req("LH ok",   1'b0, F3_H,   32'h102, 32'h0, 1'b1, 4'b0000, 32'h0, 32'hFFFF8001, 1'b0);
    req("SH mis",  1'b1, F3_H,   32'h103, 32'h1234, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
    req("F3 011",  1'b0, 3'b011, 32'h100, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
    req("SBU ill", 1'b1, F3_BU,  32'h100, 32'h77, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);

    // Valid held high across a load: next request accepted three cycles later.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h100;
    #1;
    chk("hold first en", 32'(mem_en), 32'd1);
    sb.push_back('{32'h8001BEEF, 1'b0, 2});
    @(negedge clk);
    chk("hold ready T+1", 32'(req_ready), 32'd0);
    chk("hold en T+1", 32'(mem_en), 32'd0);
    @(negedge clk);
    chk("hold ready T+2", 32'(req_ready), 32'd0);
    chk("hold resp T+2", 32'(resp_valid), 32'd1);
    e = sb.pop_front();
    chk("hold rdata", resp_rdata, e.rdata);
    @(negedge clk);
    chk("hold ready T+3", 32'(req_ready), 32'd1);
    chk("hold en T+3", 32'(mem_en), 32'd1);
    sb.push_back('{32'h8001BEEF, 1'b0, 2});
    @(posedge clk); #1;
    req_valid = 1'b0;
    collect("hold second");

    // Reset while waiting on read data: the load is dropped.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_BU; req_addr = 32'h103;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rdwait ready", 32'(req_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("midrst ready", 32'(req_ready), 32'd1);
    chk("midrst resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst rdata", resp_rdata, 32'd0);
    chk("midrst err", 32'(resp_err), 32'd0);
    chk("midrst mem_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post rst no resp", 32'(resp_valid), 32'd0);
    end
    req("LHU after rst", 1'b0, F3_HU, 32'h102, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h00008001, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
